// File: rtl/wtm_debounce_pkg.sv
// wtm_debounce_pkg: shared constants and helpers for the debouncer
package wtm_debounce_pkg;

    localparam logic [7:0] GLITCH_MAX = 8'd255;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == GLITCH_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/wtm_debounce_sigsync.sv
// wtm_sigSync: multi-flop synchronizer for a single asynchronous level
module wtm_sigSync #(
    parameter int WIDTH = 2
) (
    input  logic clock,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) r_sync <= '0;
        else        r_sync <= {r_sync[WIDTH-2:0], i_d};
    end

    assign o_q = r_sync[WIDTH-1];

endmodule

// File: rtl/wtm_debounce.sv
// wtm_debounce: synchronizes and debounces a raw level, flags edges and counts rejected bounces
module wtm_debounce
    import wtm_debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clock,
    input  logic       rst_n,
    input  logic       sig_in,
    input  logic       glitch_clr,
    output logic       level_out,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic [7:0] glitch_count
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] STABLE_LOW  = 2'd0;
    localparam logic [1:0] CHK_HIGH    = 2'd1;
    localparam logic [1:0] STABLE_HIGH = 2'd2;
    localparam logic [1:0] CHK_LOW     = 2'd3;

    logic          w_s;
    logic          w_glitch;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_rise;
    logic          r_fall;
    logic [7:0]    r_gcnt;

    wtm_sigSync #(.WIDTH(SYNC_STAGES)) u_sync (
        .clock (clock),
        .rst_n (rst_n),
        .i_d   (sig_in),
        .o_q   (w_s)
    );

    // A check aborted by the synchronized input falling back is a rejected transition
    assign w_glitch = (r_state == CHK_HIGH && !w_s) || (r_state == CHK_LOW && w_s);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= STABLE_LOW;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_gcnt  <= '0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            r_gcnt <= glitch_clr ? 8'd0 : w_glitch ? sat_inc8(r_gcnt) : r_gcnt;
            case (r_state)
                STABLE_LOW: if (w_s) begin
                    r_state <= CHK_HIGH;
                    r_cnt   <= CNT_ONE;
                end
                CHK_HIGH: if (!w_s) begin
                    r_state <= STABLE_LOW;
                    r_cnt   <= '0;
                end else if (r_cnt == CNT_LAST) begin
                    r_state <= STABLE_HIGH;
                    r_level <= 1'b1;
                    r_rise  <= 1'b1;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
                STABLE_HIGH: if (!w_s) begin
                    r_state <= CHK_LOW;
                    r_cnt   <= CNT_ONE;
                end
                CHK_LOW: if (w_s) begin
                    r_state <= STABLE_HIGH;
                    r_cnt   <= '0;
                end else if (r_cnt == CNT_LAST) begin
                    r_state <= STABLE_LOW;
                    r_level <= 1'b0;
                    r_fall  <= 1'b1;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_ONE;
                end
                default: begin
                    r_state <= STABLE_LOW;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign level_out    = r_level;
    assign rise_pulse   = r_rise;
    assign fall_pulse   = r_fall;
    assign glitch_count = r_gcnt;

endmodule

// File: tb/tb_wtm_debounce.sv
// tb_wtm_debounce: random and directed stimulus checked against a run-length reference model
module tb_wtm_debounce;

    localparam int SYNC = 2;
    localparam int DC   = 4;

    logic       clock = 1'b0;
    logic       rst_n;
    logic       sig_in;
    logic       glitch_clr;
    logic       level_out;
    logic       rise_pulse;
    logic       fall_pulse;
    logic [7:0] glitch_count;

    int n_vec = 0;
    int n_err = 0;
    int n_rise = 0;
    int n_fall = 0;

    logic [7:0] m_hist;
    logic       m_level;
    logic       m_rise;
    logic       m_fall;
    int         m_run;
    int         m_gc;

    wtm_debounce #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC)) dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .sig_in       (sig_in),
        .glitch_clr   (glitch_clr),
        .level_out    (level_out),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .glitch_count (glitch_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Level flips once the input, seen SYNC edges late, has differed from it for DC straight edges
    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            m_hist  <= '0;
            m_level <= 1'b0;
            m_rise  <= 1'b0;
            m_fall  <= 1'b0;
            m_run   <= 0;
            m_gc    <= 0;
        end else begin
            automatic logic x   = m_hist[SYNC-1];
            automatic bit   acc = (x != m_level) && (m_run + 1 == DC);
            automatic bit   gl  = (x == m_level) && (m_run > 0);
            m_hist  <= {m_hist[6:0], sig_in};
            m_run   <= (x != m_level && !acc) ? m_run + 1 : 0;
            m_level <= acc ? x : m_level;
            m_rise  <= acc && x;
            m_fall  <= acc && !x;
            m_gc    <= glitch_clr ? 0 : gl ? ((m_gc < 255) ? m_gc + 1 : 255) : m_gc;
        end
    end

    always @(posedge clock) begin
        #2;
        n_rise += int'(rise_pulse);
        n_fall += int'(fall_pulse);
    end

    always @(negedge clock) begin
        chk("level", level_out, m_level);
        chk("rise", rise_pulse, m_rise);
        chk("fall", fall_pulse, m_fall);
        chk("gcnt", glitch_count, m_gc);
        chk("excl", rise_pulse & fall_pulse, 0);
    end

    initial begin
        int r0, f0, tg;
        logic l0;
        rst_n = 1'b0;
        sig_in = 1'b0;
        glitch_clr = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_level", level_out, 0);
        chk("rst_gcnt", glitch_count, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clock);
        sig_in = 1'b1;
        repeat (5) @(negedge clock);
        chk("lat5_level", level_out, 0);
        @(negedge clock);
        chk("lat6_level", level_out, 1);
        chk("lat6_rise", rise_pulse, 1);
        @(negedge clock);
        chk("lat7_rise", rise_pulse, 0);
        repeat (4) @(negedge clock);
        sig_in = 1'b0;
        repeat (10) @(negedge clock);
        chk("fell_level", level_out, 0);
        r0 = n_rise;
        f0 = n_fall;
        sig_in = 1'b1;
        repeat (3) @(negedge clock);
        sig_in = 1'b0;
        repeat (10) @(negedge clock);
        chk("short_level", level_out, 0);
        chk("short_pulses", n_rise + n_fall - r0 - f0, 0);
        chk("short_gcnt", glitch_count, 1);
        sig_in = 1'b1;
        repeat (10) @(negedge clock);
        repeat (300) begin
            sig_in = 1'b0;
            @(negedge clock);
            sig_in = 1'b1;
            @(negedge clock);
        end
        repeat (5) @(negedge clock);
        chk("sat_level", level_out, 1);
        chk("sat_gcnt", glitch_count, 255);
        glitch_clr = 1'b1;
        @(negedge clock);
        glitch_clr = 1'b0;
        chk("clr_gcnt", glitch_count, 0);
        repeat (7) begin
            sig_in = 1'b0;
            @(negedge clock);
            sig_in = 1'b1;
            @(negedge clock);
        end
        repeat (4) @(negedge clock);
        chk("seven_gcnt", glitch_count, 7);
        sig_in = 1'b0;
        @(negedge clock);
        sig_in = 1'b1;
        repeat (2) @(negedge clock);
        chk("pre_clr_gcnt", glitch_count, 7);
        glitch_clr = 1'b1;
        @(negedge clock);
        glitch_clr = 1'b0;
        chk("clr_wins_gcnt", glitch_count, 0);
        sig_in = 1'b0;
        repeat (10) @(negedge clock);
        sig_in = 1'b1;
        repeat (4) @(negedge clock);
        rst_n = 1'b0;
        #1;
        chk("arst_level", level_out, 0);
        chk("arst_rise", rise_pulse, 0);
        chk("arst_fall", fall_pulse, 0);
        chk("arst_gcnt", glitch_count, 0);
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        repeat (5) @(negedge clock);
        chk("rel5_level", level_out, 0);
        @(negedge clock);
        chk("rel6_level", level_out, 1);
        chk("rel6_rise", rise_pulse, 1);
        chk("rel_gcnt", glitch_count, 0);
        repeat (3) @(negedge clock);
        for (int b = 0; b < 20; b++) begin
            l0 = level_out;
            r0 = n_rise;
            f0 = n_fall;
            tg = 10 + int'($urandom_range(0, 1));
            for (int t = 0; t < tg; t++) begin
                sig_in = ~sig_in;
                glitch_clr = ($urandom_range(0, 7) == 0);
                repeat ($urandom_range(1, DC - 1)) @(negedge clock);
            end
            glitch_clr = 1'b0;
            repeat (12) @(negedge clock);
            chk("burst_level", level_out, sig_in);
            chk("burst_rise", n_rise - r0, int'(!l0 && sig_in));
            chk("burst_fall", n_fall - f0, int'(l0 && !sig_in));
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
